truth_table_sequencer: RTL

- Sequencer that drives the 4-input combinational logic unit exhaustively and self-checks it.
- Steps the input vector {A,B,C,D} through every code, waits a settle interval, captures F into a truth-table register and compares it against an expected table.
- Runs as a start/done transaction with an abort, and replaces the free-running stimulus loop with a synthesizable on-chip checker.

---
 rtl/truth_table_sequencer.sv | 129 ++++++++++++
 1 files changed

// File: rtl/truth_table_sequencer.sv
// Sweeps {A,B,C,D} through every code, captures F per code into a truth table and compares it with a latched expected table.
// Each vector takes SETTLE_CYCLES+1 cycles; a start is ignored while busy, and an abort returns to IDLE with no done pulse.
module truth_table_sequencer #(
  parameter int N_IN          = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [2**N_IN-1:0]   expected,
  output logic [N_IN-1:0]      vec,
  input  logic                 f_in,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   truth,
  output logic                 match,
  output logic [N_IN:0]        mismatch_cnt,
  output logic [N_IN-1:0]      first_fail,
  output logic                 fail_valid
);

  localparam int TT_W = 2**N_IN;
  localparam logic [N_IN-1:0] LAST_VEC = '1;
  // SETTLE occupies exactly SETTLE_CYCLES cycles, so the counter is loaded one short
  // and SETTLE is skipped entirely when no settle time is asked for.
  localparam logic [3:0] CNT_LOAD = (SETTLE_CYCLES > 0) ? 4'(SETTLE_CYCLES - 1) : 4'd0;
  localparam bit HAS_SETTLE = (SETTLE_CYCLES > 0);

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, DONE} state_t;

  state_t            state, state_nx;
  logic [TT_W-1:0]   expected_q;
  logic [3:0]        settle_cnt;
  logic              miss;
  logic [N_IN:0]     cnt_inc;

  assign miss    = (f_in != expected_q[vec]);
  assign cnt_inc = mismatch_cnt + {{N_IN{1'b0}}, miss};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (start && !abort) state_nx = HAS_SETTLE ? SETTLE : CAPTURE;
      end
      SETTLE: begin
        if (abort)                 state_nx = IDLE;
        else if (settle_cnt == '0) state_nx = CAPTURE;
      end
      CAPTURE: begin
        if (abort)                 state_nx = IDLE;
        else if (vec == LAST_VEC)  state_nx = DONE;
        else                       state_nx = HAS_SETTLE ? SETTLE : CAPTURE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      expected_q   <= '0;
      settle_cnt   <= '0;
      vec          <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      truth        <= '0;
      match        <= 1'b0;
      mismatch_cnt <= '0;
      first_fail   <= '0;
      fail_valid   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            expected_q   <= expected;
            vec          <= '0;
            truth        <= '0;
            mismatch_cnt <= '0;
            fail_valid   <= 1'b0;
            first_fail   <= '0;
            match        <= 1'b0;
            settle_cnt   <= CNT_LOAD;
            busy         <= 1'b1;
          end
        end
        SETTLE: begin
          if (abort) begin
            busy <= 1'b0;
            vec  <= '0;
          end else if (settle_cnt != '0) begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        CAPTURE: begin
          if (abort) begin
            busy <= 1'b0;
            vec  <= '0;
          end else begin
            truth[vec]   <= f_in;
            mismatch_cnt <= cnt_inc;
            if (miss && !fail_valid) begin
              first_fail <= vec;
              fail_valid <= 1'b1;
            end
            if (vec == LAST_VEC) begin
              // Registered so match is valid in the same cycle as the done pulse.
              done  <= 1'b1;
              busy  <= 1'b0;
              match <= (cnt_inc == '0);
            end else begin
              vec        <= vec + 1'b1;
              settle_cnt <= CNT_LOAD;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
